// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, imem request handshake, and IF/ID pipeline register.
// A one-entry buffer holds a returned instruction while the hazard unit blocks IF/ID.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCWrite,
  input  logic        IfIdWrite,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] BranchTarget,
  input  logic [31:0] JumpTarget,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemReady,
  input  logic [31:0] ImemData,
  output logic [31:0] IfIdInst,
  output logic [31:0] IfIdPCPlus4,
  output logic        IfIdValid,
  output logic        FetchWait
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [0:0] {
    ST_FETCH = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  state_t            r_state, w_state;
  logic [XLEN-1:0]   r_pc, w_pc;
  logic [XLEN-1:0]   r_inst, w_inst;
  logic [XLEN-1:0]   r_pcp4, w_pcp4;
  logic              r_valid, w_valid;
  logic [XLEN-1:0]   r_buf_inst, w_buf_inst;
  logic [XLEN-1:0]   r_buf_pcp4, w_buf_pcp4;
  logic [XLEN-1:0]   w_pc_plus4;
  logic              w_redirect;
  logic              w_advance;

  assign w_pc_plus4 = r_pc + XLEN'(4);
  assign w_redirect = (PCSrc == 2'b01) || (PCSrc == 2'b10);
  assign w_advance  = IfIdWrite && PCWrite;

  // State register and all datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_FETCH;
      r_pc       <= RESET_PC;
      r_inst     <= '0;
      r_pcp4     <= '0;
      r_valid    <= 1'b0;
      r_buf_inst <= '0;
      r_buf_pcp4 <= '0;
    end else begin
      r_state    <= w_state;
      r_pc       <= w_pc;
      r_inst     <= w_inst;
      r_pcp4     <= w_pcp4;
      r_valid    <= w_valid;
      r_buf_inst <= w_buf_inst;
      r_buf_pcp4 <= w_buf_pcp4;
    end
  end

  // Next-state logic: redirect beats stall beats normal flow
  always_comb begin
    w_state    = r_state;
    w_pc       = r_pc;
    w_inst     = r_inst;
    w_pcp4     = r_pcp4;
    w_valid    = r_valid;
    w_buf_inst = r_buf_inst;
    w_buf_pcp4 = r_buf_pcp4;

    if (w_redirect) begin
      w_pc       = (PCSrc == 2'b01) ? BranchTarget : JumpTarget;
      w_inst     = '0;
      w_valid    = 1'b0;
      w_buf_inst = '0;
      w_buf_pcp4 = '0;
      w_state    = ST_FETCH;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (ImemReady) begin
            if (w_advance) begin
              w_inst  = ImemData;
              w_pcp4  = w_pc_plus4;
              w_valid = 1'b1;
              w_pc    = w_pc_plus4;
            end else begin
              // Returned word must not be lost while IF/ID or PC is frozen
              w_buf_inst = ImemData;
              w_buf_pcp4 = w_pc_plus4;
              w_state    = ST_HOLD;
            end
          end else if (IfIdWrite) begin
            w_inst  = '0;
            w_valid = 1'b0;
          end
        end
        ST_HOLD: begin
          if (w_advance) begin
            w_inst  = r_buf_inst;
            w_pcp4  = r_buf_pcp4;
            w_valid = 1'b1;
            w_pc    = w_pc_plus4;
            w_state = ST_FETCH;
          end
        end
        default: w_state = ST_FETCH;
      endcase
    end
  end

  assign ImemReq     = (r_state == ST_FETCH);
  assign ImemAddr    = r_pc;
  assign FetchWait   = (r_state == ST_FETCH) && !ImemReady;
  assign IfIdInst    = r_inst;
  assign IfIdPCPlus4 = r_pcp4;
  assign IfIdValid   = r_valid;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: streaming, stalls, imem wait, redirects, reset, PC wrap.
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic        PCWrite, IfIdWrite;
  logic [1:0]  PCSrc;
  logic [31:0] BranchTarget, JumpTarget;
  logic        ImemReq, ImemReady, IfIdValid, FetchWait;
  logic [31:0] ImemAddr, ImemData, IfIdInst, IfIdPCPlus4;

  logic        ImemReq2, IfIdValid2, FetchWait2;
  logic [31:0] ImemAddr2, ImemData2, IfIdInst2, IfIdPCPlus42;

  int n_checks = 0;
  int n_errors = 0;

  // Imem model: word returned is tagged with its own address
  assign ImemData  = {16'hC0DE, ImemAddr[15:0]};
  assign ImemData2 = {16'hC0DE, ImemAddr2[15:0]};

  if_stage u_dut (
    .clk(clk), .rst(rst), .PCWrite(PCWrite), .IfIdWrite(IfIdWrite), .PCSrc(PCSrc),
    .BranchTarget(BranchTarget), .JumpTarget(JumpTarget), .ImemReq(ImemReq),
    .ImemAddr(ImemAddr), .ImemReady(ImemReady), .ImemData(ImemData),
    .IfIdInst(IfIdInst), .IfIdPCPlus4(IfIdPCPlus4), .IfIdValid(IfIdValid),
    .FetchWait(FetchWait)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
    .clk(clk), .rst(rst), .PCWrite(1'b1), .IfIdWrite(1'b1), .PCSrc(2'b00),
    .BranchTarget(32'h0), .JumpTarget(32'h0), .ImemReq(ImemReq2),
    .ImemAddr(ImemAddr2), .ImemReady(1'b1), .ImemData(ImemData2),
    .IfIdInst(IfIdInst2), .IfIdPCPlus4(IfIdPCPlus42), .IfIdValid(IfIdValid2),
    .FetchWait(FetchWait2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] pc,
                          input logic [31:0] inst, input logic [31:0] pcp4,
                          input logic valid);
    check({tag, ".pc"},    ImemAddr,         pc);
    check({tag, ".inst"},  IfIdInst,         inst);
    check({tag, ".pcp4"},  IfIdPCPlus4,      pcp4);
    check({tag, ".valid"}, 32'(IfIdValid),   32'(valid));
  endtask

  initial begin
    rst = 1'b1; PCWrite = 1'b1; IfIdWrite = 1'b1; PCSrc = 2'b00;
    BranchTarget = 32'h0; JumpTarget = 32'h0; ImemReady = 1'b1;
    step(); step();

    // Reset state
    chk_ifid("rst", 32'h0, 32'h0, 32'h0, 1'b0);
    check("rst.req", 32'(ImemReq), 32'd1);
    check("rst.fwait", 32'(FetchWait), 32'd0);
    check("rst_wrap.pc", ImemAddr2, 32'hFFFF_FFFC);

    // Streaming
    rst = 1'b0;
    step();
    chk_ifid("s0", 32'h4, 32'hC0DE_0000, 32'h4, 1'b1);
    check("wrap.pc", ImemAddr2, 32'h0000_0000);
    check("wrap.pcp4", IfIdPCPlus42, 32'h0000_0000);
    check("wrap.inst", IfIdInst2, 32'hC0DE_FFFC);
    check("wrap.valid", 32'(IfIdValid2), 32'd1);
    step();
    chk_ifid("s1", 32'h8, 32'hC0DE_0004, 32'h8, 1'b1);

    // Load-use stall at PC=8
    IfIdWrite = 1'b0; PCWrite = 1'b0;
    step();
    chk_ifid("stall", 32'h8, 32'hC0DE_0004, 32'h8, 1'b1);
    check("stall.req", 32'(ImemReq), 32'd0);
    IfIdWrite = 1'b1; PCWrite = 1'b1;
    step();
    chk_ifid("unstall", 32'hC, 32'hC0DE_0008, 32'hC, 1'b1);
    check("unstall.req", 32'(ImemReq), 32'd1);
    step();
    chk_ifid("s3", 32'h10, 32'hC0DE_000C, 32'h10, 1'b1);

    // Imem wait for 3 cycles at PC=16
    ImemReady = 1'b0;
    #1 check("wait.fwait", 32'(FetchWait), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_ifid($sformatf("wait%0d", i), 32'h10, 32'h0, 32'h10, 1'b0);
      check($sformatf("wait%0d.fwait", i), 32'(FetchWait), 32'd1);
    end
    ImemReady = 1'b1;
    step();
    chk_ifid("waitdone", 32'h14, 32'hC0DE_0010, 32'h14, 1'b1);
    step();
    chk_ifid("s5", 32'h18, 32'hC0DE_0014, 32'h18, 1'b1);

    // PCWrite=0 alone still buffers (HOLD), then HOLD ignores ImemReady
    PCWrite = 1'b0;
    step();
    chk_ifid("pcw0", 32'h18, 32'hC0DE_0014, 32'h18, 1'b1);
    check("pcw0.req", 32'(ImemReq), 32'd0);
    ImemReady = 1'b0;
    step();
    chk_ifid("hold", 32'h18, 32'hC0DE_0014, 32'h18, 1'b1);
    check("hold.fwait", 32'(FetchWait), 32'd0);

    // Branch while in HOLD discards the buffered word
    PCSrc = 2'b01; BranchTarget = 32'h40; PCWrite = 1'b1;
    step();
    chk_ifid("br", 32'h40, 32'h0, 32'h18, 1'b0);
    check("br.req", 32'(ImemReq), 32'd1);
    PCSrc = 2'b00; ImemReady = 1'b1;
    step();
    chk_ifid("br1", 32'h44, 32'hC0DE_0040, 32'h44, 1'b1);

    // Jump with IfIdWrite=0: redirect wins
    PCSrc = 2'b10; JumpTarget = 32'h100; IfIdWrite = 1'b0;
    step();
    chk_ifid("jmp", 32'h100, 32'h0, 32'h44, 1'b0);
    PCSrc = 2'b00; IfIdWrite = 1'b1;
    step();
    chk_ifid("jmp1", 32'h104, 32'hC0DE_0100, 32'h104, 1'b1);

    // Reserved PCSrc behaves as sequential
    PCSrc = 2'b11; BranchTarget = 32'h200; JumpTarget = 32'h300;
    step();
    chk_ifid("rsvd", 32'h108, 32'hC0DE_0104, 32'h108, 1'b1);
    PCSrc = 2'b00;

    // Not ready and IF/ID blocked: everything held
    ImemReady = 1'b0; IfIdWrite = 1'b0;
    step();
    chk_ifid("nrhold", 32'h108, 32'hC0DE_0104, 32'h108, 1'b1);

    // Enter HOLD, then reset together with a redirect
    ImemReady = 1'b1;
    step();
    check("pre_rst.req", 32'(ImemReq), 32'd0);
    rst = 1'b1; PCSrc = 2'b01; BranchTarget = 32'h80;
    step();
    chk_ifid("rst2", 32'h0, 32'h0, 32'h0, 1'b0);
    check("rst2.req", 32'(ImemReq), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 PCWrite  input  1  from hazard unit; 0 = hold PC.
REQ-005 IfIdWrite  input  1  from hazard unit; 0 = hold IF/ID register.
REQ-006 PCSrc  input  2  00 sequential, 01 branch, 10 jump, 11 reserved (treated as 00).
REQ-007 BranchTarget  input  32  redirect address for PCSrc=01.
REQ-008 JumpTarget  input  32  redirect address for PCSrc=10.
REQ-009 ImemReq  output  1  instruction fetch request.
REQ-010 ImemAddr  output  32  fetch address, always equal to PC.
REQ-011 ImemReady  input  1  imem returns ImemData this cycle.
REQ-012 ImemData  input  32  fetched instruction.
REQ-013 IfIdInst  output  32  IF/ID instruction register.
REQ-014 IfIdPCPlus4  output  32  IF/ID PC+4 register.
REQ-015 IfIdValid  output  1  IF/ID holds a real instruction (0 = bubble).
REQ-016 FetchWait  output  1  high in FETCH state while ImemReady=0.

Function
REQ-017 States: FETCH (request outstanding), HOLD (instruction buffered, IF/ID write blocked).
REQ-018 ImemReq shall be 1 in FETCH, 0 in HOLD.
REQ-019 redirect = (PCSrc==01 or PCSrc==10); priority: rst > redirect > stall > normal.
REQ-020 Redirect: PC <= selected target; IF/ID <= bubble (Inst=0, Valid=0, PCPlus4 held); buffer discarded; state <= FETCH; applies regardless of PCWrite, IfIdWrite, ImemReady, state.
REQ-021 FETCH, ImemReady=1, IfIdWrite=1, PCWrite=1: IF/ID <= {ImemData, PC+4, Valid=1}; PC <= PC+4; stay FETCH.
REQ-022 FETCH, ImemReady=1, IfIdWrite=0: ImemData and PC+4 captured in buffer; IF/ID and PC held; state <= HOLD.
REQ-023 FETCH, ImemReady=1, IfIdWrite=1, PCWrite=0: treated as REQ-022 (no consume without PC advance).
REQ-024 FETCH, ImemReady=0, IfIdWrite=1: IF/ID <= bubble; PC held; stay FETCH.
REQ-025 FETCH, ImemReady=0, IfIdWrite=0: IF/ID and PC held; stay FETCH.
REQ-026 HOLD, IfIdWrite=1 and PCWrite=1: IF/ID <= {buffer, Valid=1}; PC <= PC+4; state <= FETCH.
REQ-027 HOLD otherwise: all registers held; ImemReady ignored.
REQ-028 PC+4 wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
REQ-029 An abandoned request (address change on redirect) needs no cancel; imem shall answer the current ImemAddr only.
REQ-030 Instruction order preserved; no instruction delivered twice or dropped except by redirect.

Reset
REQ-031 On rst=1 at an edge: PC <= RESET_PC; state <= FETCH; IfIdInst <= 0; IfIdPCPlus4 <= 0; IfIdValid <= 0; buffer <= 0.
REQ-032 rst overrides all inputs, including mid-HOLD and mid-redirect; first request after reset is ImemAddr=RESET_PC with ImemReq=1.

Verification
REQ-033 Reset, ImemReady=1 constant, no stalls -> ImemAddr 0,4,8,... one per cycle; IfIdPCPlus4 4,8,12 with Valid=1 one cycle later.
REQ-034 Load-use stall: IfIdWrite=PCWrite=0 for 1 cycle at PC=8 with ImemReady=1 -> HOLD; ImemReq=0; IF/ID keeps PC=4 instruction; next cycle IF/ID gets PC=8 instruction, PC=12.
REQ-035 ImemReady=0 for 3 cycles at PC=16 -> FetchWait=1, IF/ID bubbles (Valid=0) 3 cycles, PC=16 held; then instruction delivered once.
REQ-036 PCSrc=01, BranchTarget=0x40 while in HOLD -> next cycle PC=0x40, IfIdValid=0, buffered instruction never appears.
REQ-037 Simultaneous redirect (PCSrc=10, JumpTarget=0x100) and IfIdWrite=0 -> redirect wins: PC=0x100, IF/ID bubble.
REQ-038 RESET_PC=32'hFFFF_FFFC, ImemReady=1 -> second fetch address 0x0000_0000.
